// File: rtl/mc_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mc_pkg - shared constants, types and FSM encoding for mc_dispatch_ctrl
// Rev 1.0
// ----------------------------------------------------------------------------
package mc_pkg;

    localparam int unsigned MC_CORE_NUM = 4;
    localparam int unsigned MC_DW       = 12;
    localparam int unsigned MC_CW       = 10;

    function automatic int unsigned mc_log2(input int unsigned n);
        return $clog2(n);
    endfunction

    localparam int unsigned MC_LOG2_CORE = mc_log2(MC_CORE_NUM);

    typedef logic [MC_DW-1:0] price_t;
    typedef logic [MC_DW-1:0] path_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_DISPATCH = 3'd1,
        ST_DRAIN    = 3'd2,
        ST_REDUCE   = 3'd3,
        ST_DONE     = 3'd4
    } mc_state_t;

endpackage
`default_nettype wire

// File: rtl/mc_price_reducer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mc_price_reducer - captures per-core prices, sums them one per cycle, averages
// Rev 1.0
// ----------------------------------------------------------------------------
module mc_price_reducer
    import mc_pkg::*;
#(
    parameter int unsigned CORE_NUM = MC_CORE_NUM,
    parameter int unsigned DW       = MC_DW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_clear,
    input  logic [CORE_NUM-1:0]    i_capture,
    input  logic [CORE_NUM*DW-1:0] i_core_price,
    input  logic                   i_start,
    output logic                   o_last,
    output logic                   o_done,
    output logic [DW-1:0]          o_avg
);

    localparam int unsigned PW = mc_log2(CORE_NUM);
    localparam int unsigned AW = DW + PW;

    logic [DW-1:0] r_buf [CORE_NUM];
    logic [AW-1:0] r_acc;
    logic [PW-1:0] r_idx;
    logic          r_active;
    logic          r_done;
    logic [DW-1:0] r_avg;
    logic [AW-1:0] w_acc_next;

    // Accumulator carries PW extra bits, so a full bank of max prices cannot wrap.
    assign w_acc_next = r_acc + AW'(r_buf[r_idx]);
    assign o_last     = r_active && (r_idx == PW'(CORE_NUM - 1));
    assign o_done     = r_done;
    assign o_avg      = r_avg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < CORE_NUM; i++) r_buf[i] <= '0;
            r_acc    <= '0;
            r_idx    <= '0;
            r_active <= 1'b0;
            r_done   <= 1'b0;
            r_avg    <= '0;
        end else begin
            r_done <= 1'b0;
            if (i_clear) begin
                for (int i = 0; i < CORE_NUM; i++) r_buf[i] <= '0;
            end else begin
                for (int i = 0; i < CORE_NUM; i++) begin
                    if (i_capture[i]) r_buf[i] <= i_core_price[i*DW +: DW];
                end
            end

            if (i_start) begin
                r_active <= 1'b1;
                r_acc    <= '0;
                r_idx    <= '0;
            end else if (r_active) begin
                r_acc <= w_acc_next;
                r_idx <= r_idx + PW'(1);
                if (o_last) begin
                    r_active <= 1'b0;
                    r_done   <= 1'b1;
                    r_avg    <= DW'(w_acc_next >> PW);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/mc_dispatch_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// mc_dispatch_ctrl - round-robin path dispatch to MC cores and job price reduction
// Rev 1.0
// ----------------------------------------------------------------------------
module mc_dispatch_ctrl
    import mc_pkg::*;
#(
    parameter int unsigned CORE_NUM = MC_CORE_NUM,
    parameter int unsigned DW       = MC_DW,
    parameter int unsigned CW       = MC_CW
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   i_start,
    input  logic [DW-1:0]          i_k_in,
    input  logic [CW-1:0]          i_n_paths,
    input  logic                   i_path_valid,
    input  logic [DW-1:0]          i_path_data,
    output logic                   o_path_ready,
    output logic [DW-1:0]          o_core_k,
    output logic [CORE_NUM-1:0]    o_core_path_valid,
    output logic [CORE_NUM*DW-1:0] o_core_path,
    output logic [CORE_NUM-1:0]    o_core_last,
    input  logic [CORE_NUM-1:0]    i_core_done,
    input  logic [CORE_NUM*DW-1:0] i_core_price,
    output logic                   o_busy,
    output logic [DW-1:0]          o_price,
    output logic                   o_price_valid
);

    localparam int unsigned     PW         = mc_log2(CORE_NUM);
    localparam logic [CW-1:0]   C_LOW_MASK = CW'(CORE_NUM - 1);

    mc_state_t              r_state;
    mc_state_t              w_state_next;
    logic [PW-1:0]          r_rr_ptr;
    logic [CW-1:0]          r_remaining;
    logic [DW-1:0]          r_core_k;
    logic [CORE_NUM-1:0]    r_core_path_valid;
    logic [CORE_NUM-1:0]    r_core_last;
    logic [CORE_NUM*DW-1:0] r_core_path;
    logic [CORE_NUM-1:0]    r_last_issued;
    logic [CORE_NUM-1:0]    r_done_seen;

    logic [CW-1:0]          w_eff;
    logic                   w_job_start;
    logic                   w_accept;
    logic                   w_is_last;
    logic [CORE_NUM-1:0]    w_onehot;
    logic [CORE_NUM-1:0]    w_capture;
    logic                   w_all_done;
    logic                   w_red_last;

    // Jobs are rounded down to whole rounds so every core sees the same path count.
    assign w_eff       = i_n_paths & ~C_LOW_MASK;
    assign w_job_start = (r_state == ST_IDLE) && i_start && (w_eff != '0);
    assign w_accept    = (r_state == ST_DISPATCH) && i_path_valid;
    assign w_onehot    = CORE_NUM'(1) << r_rr_ptr;
    assign w_is_last   = (r_remaining <= CW'(CORE_NUM));
    // Stale or early done levels are masked until that core has its final sample.
    assign w_capture   = (r_state == ST_DRAIN) ? (i_core_done & r_last_issued & ~r_done_seen)
                                               : '0;
    assign w_all_done  = &(r_done_seen | w_capture);

    assign o_core_k          = r_core_k;
    assign o_core_path_valid = r_core_path_valid;
    assign o_core_path       = r_core_path;
    assign o_core_last       = r_core_last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        o_path_ready = 1'b0;
        o_busy       = 1'b1;
        case (r_state)
            ST_IDLE: begin
                o_busy = 1'b0;
                if (w_job_start) w_state_next = ST_DISPATCH;
            end
            ST_DISPATCH: begin
                o_path_ready = 1'b1;
                if (w_accept && (r_remaining == CW'(1))) w_state_next = ST_DRAIN;
            end
            ST_DRAIN:  if (w_all_done) w_state_next = ST_REDUCE;
            ST_REDUCE: if (w_red_last) w_state_next = ST_DONE;
            ST_DONE:   w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr          <= '0;
            r_remaining       <= '0;
            r_core_k          <= '0;
            r_core_path_valid <= '0;
            r_core_last       <= '0;
            r_core_path       <= '0;
            r_last_issued     <= '0;
            r_done_seen       <= '0;
        end else begin
            r_core_path_valid <= '0;
            r_core_last       <= '0;
            if (w_job_start) begin
                r_core_k      <= i_k_in;
                r_remaining   <= w_eff;
                r_rr_ptr      <= '0;
                r_done_seen   <= '0;
                r_last_issued <= '0;
            end else begin
                r_done_seen <= r_done_seen | w_capture;
            end

            if (w_accept) begin
                r_core_path_valid                <= w_onehot;
                r_core_path[r_rr_ptr*DW +: DW]   <= i_path_data;
                r_rr_ptr                         <= r_rr_ptr + PW'(1);
                r_remaining                      <= r_remaining - CW'(1);
                if (w_is_last) begin
                    r_core_last   <= w_onehot;
                    r_last_issued <= r_last_issued | w_onehot;
                end
            end
        end
    end

    mc_price_reducer #(
        .CORE_NUM (CORE_NUM),
        .DW       (DW)
    ) u_reducer (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clear      (w_job_start),
        .i_capture    (w_capture),
        .i_core_price (i_core_price),
        .i_start      ((r_state == ST_DRAIN) && w_all_done),
        .o_last       (w_red_last),
        .o_done       (o_price_valid),
        .o_avg        (o_price)
    );

endmodule
`default_nettype wire

// File: tb/tb_mc_dispatch_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_mc_dispatch_ctrl - directed jobs checked against a job-level price/dispatch model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_mc_dispatch_ctrl;

    localparam int N  = 4;
    localparam int DW = 12;
    localparam int CW = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            i_start = 1'b0;
    logic [DW-1:0]   i_k_in = '0;
    logic [CW-1:0]   i_n_paths = '0;
    logic            i_path_valid = 1'b0;
    logic [DW-1:0]   i_path_data = '0;
    logic            o_path_ready;
    logic [DW-1:0]   o_core_k;
    logic [N-1:0]    o_core_path_valid;
    logic [N*DW-1:0] o_core_path;
    logic [N-1:0]    o_core_last;
    logic [N-1:0]    i_core_done = '0;
    logic [N*DW-1:0] i_core_price = '0;
    logic            o_busy;
    logic [DW-1:0]   o_price;
    logic            o_price_valid;

    always #5 clk = ~clk;

    mc_dispatch_ctrl #(.CORE_NUM(N), .DW(DW), .CW(CW)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .i_start           (i_start),
        .i_k_in            (i_k_in),
        .i_n_paths         (i_n_paths),
        .i_path_valid      (i_path_valid),
        .i_path_data       (i_path_data),
        .o_path_ready      (o_path_ready),
        .o_core_k          (o_core_k),
        .o_core_path_valid (o_core_path_valid),
        .o_core_path       (o_core_path),
        .o_core_last       (o_core_last),
        .i_core_done       (i_core_done),
        .i_core_price      (i_core_price),
        .o_busy            (o_busy),
        .o_price           (o_price),
        .o_price_valid     (o_price_valid)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Job-level model: phase 0 idle, 1 taking paths, 2 waiting for cores, 3 reducing.
    int            m_phase = 0;
    int            m_rem = 0;
    int            m_cnt = 0;
    int            m_cd = 0;
    int            m_buf [N];
    logic [DW-1:0] m_k = '0;
    logic [DW-1:0] m_price = '0;
    logic [N-1:0]  m_exp_valid = '0;
    logic [N-1:0]  m_exp_last = '0;
    logic [N-1:0]  m_last_sent = '0;
    logic [N-1:0]  m_seen = '0;
    logic [DW-1:0] m_exp_data [N];

    int rec_data [N][$];
    bit rec_last [N][$];

    always @(negedge clk) begin : p_compare
        int c;
        int sum;
        if (!rst_n) begin
            check("rst_busy", 64'(o_busy), 64'(0));
            check("rst_path_ready", 64'(o_path_ready), 64'(0));
            check("rst_core_valid", 64'(o_core_path_valid), 64'(0));
            check("rst_core_last", 64'(o_core_last), 64'(0));
            check("rst_core_path", 64'(o_core_path), 64'(0));
            check("rst_core_k", 64'(o_core_k), 64'(0));
            check("rst_price", 64'(o_price), 64'(0));
            check("rst_price_valid", 64'(o_price_valid), 64'(0));
            m_phase = 0; m_rem = 0; m_cnt = 0; m_cd = 0;
            m_k = '0; m_price = '0; m_exp_valid = '0; m_exp_last = '0;
            m_last_sent = '0; m_seen = '0;
        end else begin
            check("busy", 64'(o_busy), 64'(m_phase != 0));
            check("path_ready", 64'(o_path_ready), 64'(m_phase == 1));
            check("core_valid", 64'(o_core_path_valid), 64'(m_exp_valid));
            check("core_last", 64'(o_core_last), 64'(m_exp_last));
            check("core_k", 64'(o_core_k), 64'(m_k));
            check("price_valid", 64'(o_price_valid), 64'(m_phase == 3 && m_cd == 0));
            if (m_phase != 3 || m_cd == 0) check("price", 64'(o_price), 64'(m_price));
            for (int i = 0; i < N; i++) begin
                if (m_exp_valid[i])
                    check($sformatf("core_path%0d", i), 64'(o_core_path[i*DW +: DW]),
                          64'(m_exp_data[i]));
                if (o_core_path_valid[i]) begin
                    rec_data[i].push_back(int'(o_core_path[i*DW +: DW]));
                    rec_last[i].push_back(o_core_last[i]);
                end
            end

            m_exp_valid = '0;
            m_exp_last  = '0;
            case (m_phase)
                0: begin
                    if (i_start && (int'(i_n_paths) / N) != 0) begin
                        m_phase = 1;
                        m_k = i_k_in;
                        m_rem = (int'(i_n_paths) / N) * N;
                        m_cnt = 0;
                        m_seen = '0;
                        m_last_sent = '0;
                    end
                end
                1: begin
                    if (i_path_valid) begin
                        c = m_cnt % N;
                        m_exp_valid[c] = 1'b1;
                        m_exp_data[c] = i_path_data;
                        if (m_rem <= N) begin
                            m_exp_last[c] = 1'b1;
                            m_last_sent[c] = 1'b1;
                        end
                        m_cnt++;
                        m_rem--;
                        if (m_rem == 0) m_phase = 2;
                    end
                end
                2: begin
                    for (int i = 0; i < N; i++) begin
                        if (i_core_done[i] && m_last_sent[i] && !m_seen[i]) begin
                            m_seen[i] = 1'b1;
                            m_buf[i] = int'(i_core_price[i*DW +: DW]);
                        end
                    end
                    if (&m_seen) begin
                        sum = 0;
                        for (int i = 0; i < N; i++) sum += m_buf[i];
                        m_price = DW'(sum / N);
                        m_phase = 3;
                        m_cd = N;
                    end
                end
                default: begin
                    if (m_cd == 0) m_phase = 0;
                    else m_cd--;
                end
            endcase
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) tick();
    endtask

    task automatic set_core(input int i, input int p, input logic d);
        i_core_price[i*DW +: DW] = DW'(p);
        i_core_done[i] = d;
    endtask

    task automatic done_all(input int p0, input int p1, input int p2, input int p3);
        set_core(0, p0, 1'b1);
        set_core(1, p1, 1'b1);
        set_core(2, p2, 1'b1);
        set_core(3, p3, 1'b1);
    endtask

    task automatic start_job(input int k, input int n);
        for (int i = 0; i < N; i++) begin
            rec_data[i].delete();
            rec_last[i].delete();
        end
        i_core_done = '0;
        i_start   = 1'b1;
        i_k_in    = DW'(k);
        i_n_paths = CW'(n);
        tick();
        i_start = 1'b0;
    endtask

    task automatic send_seq(input int base, input int count, input bit gapped);
        for (int j = 0; j < count; j++) begin
            i_path_valid = 1'b1;
            i_path_data  = DW'(base + j);
            tick();
            if (gapped) begin
                i_path_valid = 1'b0;
                tick();
            end
        end
        i_path_valid = 1'b0;
    endtask

    // Cycles from the cycle the final done is driven until price_valid (-1 on timeout).
    task automatic wait_price(output int lat, output int p);
        lat = -1;
        p = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (o_price_valid) begin
                lat = k;
                p = int'(o_price);
                break;
            end
        end
        tick();
    endtask

    initial begin : p_stim
        int lat;
        int p;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();

        // Basic job
        start_job(2048, 8);
        send_seq(1, 8, 1'b0);
        idle(3);
        done_all(100, 200, 300, 400);
        wait_price(lat, p);
        check("basic_latency", 64'(lat), 64'(5));
        check("basic_price", 64'(p), 64'(250));
        check("basic_c0_count", 64'(rec_data[0].size()), 64'(2));
        check("basic_c0_first", 64'(rec_data[0][0]), 64'(1));
        check("basic_c0_second", 64'(rec_data[0][1]), 64'(5));
        check("basic_c0_last", 64'({rec_last[0][0], rec_last[0][1]}), 64'(2'b01));
        check("basic_c3_first", 64'(rec_data[3][0]), 64'(4));
        check("basic_c3_second", 64'(rec_data[3][1]), 64'(8));
        check("basic_c3_last", 64'({rec_last[3][0], rec_last[3][1]}), 64'(2'b01));

        // Gapped stream
        start_job(100, 4);
        send_seq(11, 4, 1'b1);
        idle(1);
        for (int i = 0; i < N; i++) begin
            check($sformatf("gap_c%0d_count", i), 64'(rec_data[i].size()), 64'(1));
            check($sformatf("gap_c%0d_data", i), 64'(rec_data[i][0]), 64'(11 + i));
        end
        done_all(10, 20, 30, 40);
        wait_price(lat, p);
        check("gap_price", 64'(p), 64'(25));

        // Rounding: 6 -> 4 paths, 3 -> ignored
        start_job(7, 6);
        send_seq(31, 4, 1'b0);
        idle(1);
        for (int i = 0; i < N; i++)
            check($sformatf("round_c%0d_last", i), 64'(rec_last[i][0]), 64'(1));
        done_all(0, 0, 0, 4);
        wait_price(lat, p);
        check("round_price", 64'(p), 64'(1));
        start_job(9, 3);
        @(negedge clk);
        check("round3_busy", 64'(o_busy), 64'(0));
        check("round3_ready", 64'(o_path_ready), 64'(0));
        tick();

        // Early done on core2, real dones in order 3,1,0,2
        start_job(500, 8);
        for (int j = 0; j < 8; j++) begin
            if (j == 4) set_core(2, 999, 1'b1);
            if (j == 6) set_core(2, 999, 1'b0);
            i_path_valid = 1'b1;
            i_path_data  = DW'(21 + j);
            tick();
        end
        i_path_valid = 1'b0;
        idle(2);
        set_core(3, 40, 1'b1); idle(2);
        set_core(1, 21, 1'b1); idle(2);
        set_core(0, 10, 1'b1); idle(3);
        set_core(2, 30, 1'b1);
        wait_price(lat, p);
        check("ooo_latency", 64'(lat), 64'(5));
        check("ooo_price", 64'(p), 64'(25));

        // Saturation
        start_job(4095, 4);
        send_seq(1, 4, 1'b0);
        idle(1);
        done_all(4095, 4095, 4095, 4095);
        wait_price(lat, p);
        check("sat_price", 64'(p), 64'(4095));

        // Control robustness: start during dispatch, then reset mid-dispatch
        start_job(12'h123, 8);
        send_seq(1, 3, 1'b0);
        i_start = 1'b1; i_k_in = 12'h456; i_n_paths = 10'd4;
        i_path_valid = 1'b1; i_path_data = 12'd4;
        tick();
        i_start = 1'b0;
        send_seq(5, 2, 1'b0);
        @(negedge clk);
        check("ctl_core_k", 64'(o_core_k), 64'(12'h123));
        check("ctl_busy", 64'(o_busy), 64'(1));
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("ctl_rst_busy", 64'(o_busy), 64'(0));
        check("ctl_rst_price", 64'(o_price), 64'(0));
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        start_job(5, 4);
        send_seq(61, 4, 1'b0);
        idle(1);
        check("fresh_c0_data", 64'(rec_data[0][0]), 64'(61));
        done_all(8, 8, 8, 8);
        wait_price(lat, p);
        check("fresh_latency", 64'(lat), 64'(5));
        check("fresh_price", 64'(p), 64'(8));

        idle(2);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin : p_watchdog
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/mc_dispatch_ctrl.md
Name: mc_dispatch_ctrl

Overview:
- Job-level scheduler for a bank of CORE_NUM Monte Carlo pricing cores.
- Accepts a job (strike K, path count) and a valid/ready stream of 12-bit path samples.
- Dispatches samples round-robin to the cores and marks each core's final sample.
- Waits for all cores to report done, reduces their prices sequentially, and emits the averaged option price with a one-cycle valid pulse.

Parameters:
- CORE_NUM, 4, number of MC cores; power of two, >= 2.
- DW, 12, price/path/strike width.
- CW, 10, path-count width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- start  in  1  job start request; sampled only in IDLE.
- k_in  in  DW  strike for the job; latched on accepted start.
- n_paths  in  CW  total paths for the job; latched on accepted start.
- path_valid  in  1  path sample valid.
- path_data  in  DW  path sample.
- path_ready  out  1  controller accepts path_data this cycle.
- core_k  out  DW  latched strike, broadcast to all cores.
- core_path_valid  out  CORE_NUM  one-hot sample strobe, per core.
- core_path  out  CORE_NUM*DW  per-core sample; slice i goes to core i.
- core_last  out  CORE_NUM  asserted with core_path_valid[i] on that core's final sample.
- core_done  in  CORE_NUM  core i result valid; level, held until the next job.
- core_price  in  CORE_NUM*DW  per-core average price.
- busy  out  1  high in every state except IDLE.
- price  out  DW  job price; held until the next price_valid.
- price_valid  out  1  one-cycle pulse.

Behaviour:
- Reset values: all outputs 0, state IDLE, rr_ptr 0, remaining 0, done_seen 0, accumulator 0.
- States: IDLE, DISPATCH, DRAIN, REDUCE, DONE.
- IDLE:
  - path_ready=0.
  - start=1 → eff = n_paths with low log2(CORE_NUM) bits cleared.
  - If eff==0, start is ignored.
  - Otherwise latch core_k=k_in and remaining=eff; clear rr_ptr, done_seen and price_buf; go to DISPATCH.
- DISPATCH:
  - path_ready=1, combinational from state.
  - On path_valid & path_ready, next cycle: core_path_valid[rr_ptr]=1 and core_path slice rr_ptr=path_data (registered, 1-cycle latency). core_last[rr_ptr]=1 iff remaining<=CORE_NUM at acceptance.
  - Same edge: rr_ptr wraps mod CORE_NUM; remaining decrements.
  - Accepting with remaining==1 → DRAIN.
  - No acceptance → strobes 0, pointer held.
- DRAIN:
  - path_ready=0.
  - core_done[i] is recorded into done_seen[i] only after core_last[i] has been issued. At that capture, core_price slice i is stored into price_buf[i]. Earlier core_done assertions are ignored.
  - done_seen all ones → REDUCE; acc=0, idx=0.
- REDUCE:
  - One cycle per core: acc += price_buf[idx], idx++.
  - acc width DW+log2(CORE_NUM); it cannot overflow.
  - After CORE_NUM cycles → DONE.
- DONE:
  - price = acc >> log2(CORE_NUM), truncating.
  - price_valid=1 for exactly one cycle; next state IDLE.
- Latency: done_seen complete at cycle t → price_valid at t+CORE_NUM+1.
- start outside IDLE is ignored, and the latched job is unchanged.
- Simultaneous done on several cores in one cycle: all are captured.
- rst_n asserted mid-job: immediate return to reset values; cores are reset by the same rst_n.
- core_done held from a prior job is masked, because done_seen is cleared on start and last-gating applies.

Decomposition:
- Package mc_pkg holds: DW, CW, CORE_NUM defaults, state enum, LOG2_CORE constant/function, price_t/path_t typedefs.
- One sub-module, mc_price_reducer: price_buf capture, sequential accumulate, and shift. Its interface is start, done, and the average.
- Dispatch FSM and round-robin logic stay in the top.

Test Plan:
- Basic job:
  - Stimulus: n_paths=8, k_in=2048, paths 1..8 on consecutive cycles; cores done with prices 100, 200, 300, 400.
  - Required: core0 gets 1 then 5 (last on 5), core3 gets 4 then 8 (last on 8); path_ready drops after path 8; price_valid with price=250 five cycles after the final done.
- Gapped stream:
  - Stimulus: path_valid alternating 1/0 for n_paths=4.
  - Required: strobes only follow valid cycles, order is core0..core3, no core receives a duplicate sample.
- Rounding:
  - Stimulus: n_paths=6, then n_paths=3.
  - Required: n_paths=6 dispatches 4 paths, each carrying core_last. n_paths=3 leaves busy=0 and path_ready=0.
- Out-of-order and early done:
  - Stimulus: core2 asserts done before its last sample; real dones arrive in order 3, 1, 0, 2.
  - Required: the early done is ignored; price_valid only after core2's post-last done; price correct.
- Saturation:
  - Stimulus: all core prices 4095.
  - Required: price=4095, no wrap.
- Control robustness:
  - Stimulus: start pulsed during DISPATCH; later rst_n low mid-DISPATCH.
  - Required: the start has no effect. After reset all outputs are 0, state is IDLE, and a fresh job completes normally.
